example_mc_core: RTL and testbench



---
 rtl/example_mc_pkg.sv | 19 +
 rtl/example_mc_if.sv | 38 +++
 rtl/example_mc_fifo.sv | 50 +++++
 rtl/example_mc_core.sv | 222 ++++++++++++++++++++++
 tb/tb_example_mc_core.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/example_mc_pkg.sv
// Shared types and constants for the multi-channel merge core.
// State encoding, register map and channel-index width helper.
package example_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int REG_MASK   = 0;
  localparam int REG_LENGTH = 1;
  localparam int REG_OFF0   = 2;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/example_mc_if.sv
// Stream and configuration bus of example_mc_core.
// slave is the core side, master the producer/consumer/host side.
interface example_mc_if
  import example_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = ch_width(NUM_CH)
);

  logic [NUM_CH*DATA_WIDTH-1:0] data_in_i;
  logic [NUM_CH-1:0]            valid_in_i;
  logic [NUM_CH-1:0]            ready_in_o;
  logic [DATA_WIDTH-1:0]        data_out_o;
  logic [CH_W-1:0]              chan_out_o;
  logic                         valid_out_o;
  logic                         ready_out_i;
  logic [ADDR_WIDTH-1:0]        config_addr_i;
  logic [DATA_WIDTH-1:0]        config_data_i;
  logic                         config_valid_i;
  logic                         config_ready_o;

  modport master (
    output data_in_i, valid_in_i, ready_out_i,
    output config_addr_i, config_data_i, config_valid_i,
    input  ready_in_o, data_out_o, chan_out_o,
    input  valid_out_o, config_ready_o
  );

  modport slave (
    input  data_in_i, valid_in_i, ready_out_i,
    input  config_addr_i, config_data_i, config_valid_i,
    output ready_in_o, data_out_o, chan_out_o,
    output valid_out_o, config_ready_o
  );

endinterface

// File: rtl/example_mc_fifo.sv
// Per-channel synchronous FIFO with flush; full/empty come from
// registered state only, so a read never raises ready the same cycle.
module example_mc_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [AW:0]           r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign full_o    = (r_cnt == FULL_CNT);
  assign empty_o   = (r_cnt == '0);
  assign w_push    = wr_en_i && !full_o;
  assign w_pop     = rd_en_i && !empty_o;
  assign rd_data_o = r_mem[r_rp];

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= wr_data_i;
  end

endmodule

// File: rtl/example_mc_core.sv
// Round-robin merge of NUM_CH buffered streams with per-channel offset.
// EXAMPLE_MC_OFFSET_EN enables the output offset adder.
module example_mc_core
  import example_mc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 16,
  parameter int NUM_CH       = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [DATA_WIDTH-1:0] status_o,
  example_mc_if.slave           bus
);

  localparam int CH_W = ch_width(NUM_CH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [ADDR_WIDTH-1:0] A_MASK = ADDR_WIDTH'(REG_MASK);
  localparam logic [ADDR_WIDTH-1:0] A_LEN  = ADDR_WIDTH'(REG_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] A_OFF0 = ADDR_WIDTH'(REG_OFF0);
  localparam logic [ADDR_WIDTH-1:0] A_LAST =
    ADDR_WIDTH'(REG_OFF0 + NUM_CH - 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [1:0]            r_state;
  logic [NUM_CH-1:0]     r_mask;
  logic [DATA_WIDTH-1:0] r_len;
  logic [DATA_WIDTH-1:0] r_issued;
  logic [DATA_WIDTH-1:0] r_xfer;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [CH_W-1:0]       r_chan;
  logic                  r_vout;
  logic [CH_W-1:0]       r_ptr;

  logic [NUM_CH-1:0]     w_full;
  logic [NUM_CH-1:0]     w_empty;
  logic [NUM_CH-1:0]     w_wr;
  logic [NUM_CH-1:0]     w_rd;
  logic [DATA_WIDTH-1:0] w_rdata [NUM_CH];
  logic [DATA_WIDTH-1:0] w_word;
  logic [CH_W-1:0]       w_gnt;
  logic                  w_gnt_vld;
  logic                  w_issue;
  logic                  w_xfer;
  logic                  w_start;
  logic                  w_len_err;
  logic                  w_cfg;
  logic                  w_a_mask;
  logic                  w_a_len;
  logic                  w_a_bad;

  assign bus.ready_in_o =
    {NUM_CH{enable_i}} & r_mask & ~w_full;
  assign w_wr = bus.valid_in_i & bus.ready_in_o;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    example_mc_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUFFER_DEPTH)
    ) u_fifo (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .flush_i   (clear_i),
      .wr_en_i   (w_wr[c]),
      .wr_data_i (bus.data_in_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en_i   (w_rd[c]),
      .rd_data_o (w_rdata[c]),
      .full_o    (w_full[c]),
      .empty_o   (w_empty[c])
    );
  end

  // First eligible channel at or after r_ptr, wrapping
  always_comb begin
    logic [CH_W-1:0] v_idx;
    v_idx     = '0;
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      v_idx = CH_W'((int'(r_ptr) + i) % NUM_CH);
      if (!w_gnt_vld && r_mask[v_idx] && !w_empty[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = v_idx;
      end
    end
  end

  assign w_xfer  = r_vout && bus.ready_out_i;
  assign w_issue = (r_state == S_RUN) && enable_i && !clear_i
                && (r_issued < r_len)
                && (!r_vout || bus.ready_out_i) && w_gnt_vld;

  always_comb begin
    w_rd        = '0;
    w_rd[w_gnt] = w_issue;
  end

  assign w_start   = (r_state == S_IDLE) && start_i && enable_i
                  && (r_len != '0);
  assign w_len_err = (r_state == S_IDLE) && start_i && (r_len == '0);

  assign w_cfg    = bus.config_valid_i && bus.config_ready_o;
  assign w_a_mask = (bus.config_addr_i == A_MASK);
  assign w_a_len  = (bus.config_addr_i == A_LEN);
  assign w_a_bad  = (bus.config_addr_i > A_LAST);

`ifdef EXAMPLE_MC_OFFSET_EN
  logic [DATA_WIDTH-1:0] r_off [NUM_CH];
  logic [CH_W-1:0]       w_off_idx;
  logic                  w_a_off;

  assign w_off_idx = CH_W'(bus.config_addr_i - A_OFF0);
  assign w_a_off   = (bus.config_addr_i >= A_OFF0) && !w_a_bad;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < NUM_CH; c++) r_off[c] <= '0;
    end else if (w_cfg && w_a_off) begin
      r_off[w_off_idx] <= bus.config_data_i;
    end
  end

  assign w_word = w_rdata[w_gnt] + r_off[w_gnt];
`else
  assign w_word = w_rdata[w_gnt];
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mask <= '1;
      r_len  <= '0;
    end else if (w_cfg) begin
      unique case (1'b1)
        w_a_mask: r_mask <= bus.config_data_i[NUM_CH-1:0];
        w_a_len:  r_len  <= bus.config_data_i;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_err <= 1'b0;
    end else if ((w_cfg && w_a_bad) || w_len_err) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_start) r_state <= S_RUN;
        S_RUN:  if (w_xfer && (r_xfer + 1'b1 == r_len))
                  r_state <= S_DONE;
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_issued <= '0;
      r_xfer   <= '0;
    end else if (w_start) begin
      r_issued <= '0;
      r_xfer   <= '0;
    end else begin
      if (w_issue) r_issued <= r_issued + 1'b1;
      if (w_xfer)  r_xfer   <= r_xfer + 1'b1;
    end
  end

  // Output word holds until taken; enable_i never withdraws it
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_vout <= 1'b0;
      r_dout <= '0;
      r_chan <= '0;
    end else if (clear_i) begin
      r_vout <= 1'b0;
    end else if (w_issue) begin
      r_vout <= 1'b1;
      r_dout <= w_word;
      r_chan <= w_gnt;
    end else if (w_xfer) begin
      r_vout <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= (w_gnt == LAST_CH) ? '0 : w_gnt + 1'b1;
    end
  end

  assign busy_o             = (r_state == S_RUN);
  assign done_o             = (r_state == S_DONE);
  assign error_o            = r_err;
  assign status_o           = r_xfer;
  assign bus.config_ready_o = (r_state != S_RUN);
  assign bus.data_out_o     = r_dout;
  assign bus.chan_out_o     = r_chan;
  assign bus.valid_out_o    = r_vout;

endmodule

// File: tb/tb_example_mc_core.sv
// Self-checking bench for example_mc_core: offset table, ordering,
// backpressure, error and clear sequences with a per-channel scoreboard.
module tb_example_mc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic        clr;
  logic        busy;
  logic        done_s;
  logic        err;
  logic [31:0] status;

  example_mc_if #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .NUM_CH     (4)
  ) bus ();

  example_mc_core #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (8),
    .BUFFER_DEPTH (16),
    .NUM_CH       (4)
  ) dut (
    .clk_i    (clk),
    .reset_i  (rst),
    .enable_i (en),
    .start_i  (start),
    .clear_i  (clr),
    .busy_o   (busy),
    .done_o   (done_s),
    .error_o  (err),
    .status_o (status),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_hs = 0;
  int          n_done = 0;
  int          last_hs_cyc = -10;
  logic [31:0] last_data;
  logic [31:0] exp_q [4][$];
  logic [1:0]  got_ch [$];
  int          hs_cyc [$];
  logic [31:0] off_m [4];

  typedef struct {
    int          ch;
    logic [31:0] off;
    logic [31:0] word;
    logic [31:0] exp_on;
    logic [31:0] exp_off;
  } ofs_vec_t;
  ofs_vec_t tv [4];

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int c;
    if (!rst) begin
      if (bus.valid_out_o && bus.ready_out_i) begin
        c = int'(bus.chan_out_o);
        n_hs++;
        last_hs_cyc = cyc;
        last_data = bus.data_out_o;
        hs_cyc.push_back(cyc);
        got_ch.push_back(bus.chan_out_o);
        if (exp_q[c].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_empty: ch%0d got %0h want none",
                   c, bus.data_out_o);
        end else begin
          chk("sb_data", bus.data_out_o, exp_q[c].pop_front());
        end
      end
      if (done_s) begin
        n_done++;
        chk("done_timing", cyc, last_hs_cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    bus.config_addr_i  = a;
    bus.config_data_i  = d;
    bus.config_valid_i = 1'b1;
    tick();
    bus.config_valid_i = 1'b0;
  endtask

  task automatic push(input int ch, input logic [31:0] w);
    bus.data_in_i[ch*32 +: 32] = w;
    bus.valid_in_i[ch] = 1'b1;
    exp_q[ch].push_back(w + off_m[ch]);
    tick();
    bus.valid_in_i = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_s) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("busy_low_in_done", busy, 0);
      tick();
      chk("done_one_cycle", done_s, 0);
      chk("idle_cfg_ready", bus.config_ready_o, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d_hold;
    logic [1:0]  c_hold;
    logic [31:0] e;
    bit          seen;
    int          base;
    int          nd0;
    int          nv;

    tv[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h0000_0002};
    tv[1] = '{0, 32'h0000_0100, 32'h0000_0055, 32'h0000_0155, 32'h0000_0055};
    tv[2] = '{3, 32'h8000_0000, 32'h8000_0001, 32'h0000_0001, 32'h8000_0001};
    tv[3] = '{1, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    for (int c = 0; c < 4; c++) off_m[c] = '0;

    rst = 1'b1; en = 1'b1; start = 1'b0; clr = 1'b0;
    bus.data_in_i = '0; bus.valid_in_i = '0; bus.ready_out_i = 1'b0;
    bus.config_addr_i = '0; bus.config_data_i = '0;
    bus.config_valid_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_done", done_s, 0);
    chk("rst_error", err, 0);
    chk("rst_ready_in", bus.ready_in_o, 4'hF);
    chk("rst_data_out", bus.data_out_o, 0);
    chk("rst_chan_out", bus.chan_out_o, 0);
    chk("rst_valid_out", bus.valid_out_o, 0);
    chk("rst_cfg_ready", bus.config_ready_o, 1);
    chk("rst_status", status, 0);

    // Basic run: one word per channel, round-robin from channel 0
    bus.ready_out_i = 1'b1;
    cfg_write(8'h01, 32'd4);
    push(0, 32'h10); push(1, 32'h20); push(2, 32'h30); push(3, 32'h40);
    got_ch.delete();
    pulse_start();
    chk("run_busy", busy, 1);
    chk("run_cfg_ready", bus.config_ready_o, 0);
    wait_done(20);
    chk("order_len", got_ch.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_ch.size()) chk("order_ch", got_ch[i], i);
    chk("status_4", status, 4);

    // Latency: accept in N, valid in N+2
    cfg_write(8'h01, 32'd1);
    pulse_start();
    push(1, 32'h77);
    chk("lat_n1_valid", bus.valid_out_o, 0);
    tick();
    chk("lat_n2_valid", bus.valid_out_o, 1);
    wait_done(5);

    // Offset table incl. wrap
    for (int i = 0; i < 4; i++) begin
      cfg_write(8'(2 + tv[i].ch), tv[i].off);
`ifdef EXAMPLE_MC_OFFSET_EN
      off_m[tv[i].ch] = tv[i].off;
      e = tv[i].exp_on;
`else
      e = tv[i].exp_off;
`endif
      push(tv[i].ch, tv[i].word);
      cfg_write(8'h01, 32'd1);
      pulse_start();
      wait_done(10);
      chk("ofs_tbl_data", last_data, e);
      chk("ofs_tbl_status", status, 1);
    end
    chk("ofs_no_error", err, 0);
    for (int c = 0; c < 4; c++) begin
      cfg_write(8'(2 + c), 32'h0);
      off_m[c] = '0;
    end

    // FIFO full on ch1 and back-to-back drain
    for (int i = 0; i < 16; i++) push(1, 32'h1000 + i);
    chk("full_ready1", bus.ready_in_o[1], 0);
    chk("full_ready0", bus.ready_in_o[0], 1);
    cfg_write(8'h01, 32'd16);
    hs_cyc.delete();
    pulse_start();
    chk("full_ready_run", bus.ready_in_o[1], 0);
    tick();
    chk("ready_restored", bus.ready_in_o[1], 1);
    wait_done(40);
    chk("b2b_count", hs_cyc.size(), 16);
    if (hs_cyc.size() == 16) chk("b2b_span", hs_cyc[15] - hs_cyc[0], 15);
    chk("status_16", status, 16);

    // Backpressure hold with enable toggling
    push(0, 32'hA5); push(3, 32'h5A);
    cfg_write(8'h01, 32'd2);
    bus.ready_out_i = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.valid_out_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold_valid_seen", seen, 1);
    d_hold = bus.data_out_o;
    c_hold = bus.chan_out_o;
    for (int k = 0; k < 5; k++) begin
      en = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      #1;
      chk("hold_ready_in", bus.ready_in_o, en ? 4'hF : 4'h0);
      tick();
      chk("hold_valid", bus.valid_out_o, 1);
      chk("hold_data", bus.data_out_o, d_hold);
      chk("hold_chan", bus.chan_out_o, c_hold);
    end
    en = 1'b1;
    bus.ready_out_i = 1'b1;
    wait_done(10);

    // Errors: bad address, zero length; clear drops them
    cfg_write(8'h06, 32'h1234);
    chk("bad_addr_err", err, 1);
    pulse_clear();
    chk("clear_err", err, 0);
    push(2, 32'h7);
    cfg_write(8'h01, 32'd1);
    pulse_start();
    wait_done(10);
    chk("bad_addr_noeffect", last_data, 32'h7);
    cfg_write(8'h01, 32'd0);
    pulse_start();
    chk("len0_err", err, 1);
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_idle", busy, 0);
    pulse_clear();
    chk("clear_err2", err, 0);

    // Clear mid-run after two transfers
    cfg_write(8'h01, 32'd8);
    for (int c = 0; c < 4; c++) begin
      push(c, 32'h600 + c);
      push(c, 32'h700 + c);
    end
    base = n_hs;
    nd0 = n_done;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (n_hs - base >= 2) break;
    end
    chk("mid_hs_count", n_hs - base, 2);
    bus.ready_out_i = 1'b0;
    pulse_clear();
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    chk("mid_clr_busy", busy, 0);
    chk("mid_clr_valid", bus.valid_out_o, 0);
    chk("mid_clr_status", status, 0);
    chk("mid_clr_err", err, 0);
    cfg_write(8'h01, 32'd1);
    bus.ready_out_i = 1'b1;
    pulse_start();
    chk("flush_run_busy", busy, 1);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.valid_out_o) nv++;
    end
    chk("flush_fifo_empty", nv, 0);
    pulse_clear();
    chk("mid_no_done", n_done - nd0, 0);
    start = 1'b1;
    clr = 1'b1;
    tick();
    start = 1'b0;
    clr = 1'b0;
    chk("start_clr_idle", busy, 0);
    tick();
    chk("start_clr_idle2", busy, 0);

    chk("sb_drained",
        exp_q[0].size() + exp_q[1].size() + exp_q[2].size()
        + exp_q[3].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
